axi_fb_audio_read_arbiter: RTL and testbench
============================================

Name: axi_fb_audio_read_arbiter

Overview:
- Shares the single AXI4 read master (AR/R channels) between the HDMI line-fetch requester and four audio FIFO refill requesters.
- Video has strict priority. Audio channels are served round-robin.
- Exactly one burst is outstanding at a time; R beats are tagged with the owning requester and forwarded to a common sink.
- Sits between the framebuffer/audio fill logic and the M00_AXI port of the HDMI/audio top.

Parameters:
- C_M00_AXI_ADDR_WIDTH, 32, AXI address width
- C_M00_AXI_DATA_WIDTH, 64, AXI data width; arsize = log2(width/8)
- C_M00_AXI_ID_WIDTH, 1, arid width; arid is driven to 0
- N_AUD, 4, number of audio requesters (fixed at 4 for this build)
- STARVE_LIMIT, 8, consecutive video grants allowed while audio is pending (used only with the optional feature)

Ports:
- m00_axi_aclk in 1: sole clock
- m00_axi_aresetn in 1: synchronous, active-low reset
- vid_req in 1: video burst request; held high until vid_gnt
- vid_addr in 32: video byte address
- vid_len in 8: video AXI arlen (beats-1)
- vid_gnt out 1: one-cycle pulse on video AR handshake
- aud_req in 4: per-channel audio request; held until the matching aud_gnt bit
- aud_addr in 128: 4x32 byte addresses; ch0 in bits [31:0]
- aud_len in 32: 4x8 arlen values
- aud_gnt out 4: one-hot pulse on AR handshake
- m00_axi_araddr/arlen/arsize/arburst/arid/arvalid out: AXI AR channel
- m00_axi_arready in 1: AXI AR channel
- m00_axi_rdata in 64, m00_axi_rresp in 2, m00_axi_rlast in 1, m00_axi_rvalid in 1: AXI R channel
- m00_axi_rready out 1: AXI R channel
- rd_data out 64: forwarded beat
- rd_valid out 1: forwarded beat valid
- rd_last out 1: last beat of burst
- rd_owner out 3: 0=video, 1..4=audio ch0..3
- rd_ready in 1: sink ready
- burst_done out 5: one-cycle pulse per owner after the last beat (bit0 video, bits1-4 audio)
- m00_axi_error out 1: sticky error flag
- m00_axi_machine_busy out 1: high whenever state != IDLE

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - state=IDLE; all outputs 0 except arburst=2'b01 and arsize=3'd3.
  - rr_ptr=3, so ch0 wins first; starve_cnt=0; error cleared.
  - Any in-flight burst is abandoned. The slave is assumed reset together with the arbiter.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If vid_req, select video; otherwise, if any aud_req, select the first set bit searching rr_ptr+1, rr_ptr+2, ... mod 4.
  - Latch owner, address and length. Go to ADDR next cycle with arvalid=1. Request-to-arvalid latency is 1 cycle.
  - With no request, stay in IDLE.
- ADDR:
  - araddr, arlen and arvalid are held stable until arready.
  - On the arvalid&&arready edge: pulse vid_gnt or aud_gnt[owner] for that cycle, clear arvalid, and go to DATA.
  - rr_ptr updates to the granted channel on audio grants only.
- DATA:
  - m00_axi_rready = rd_ready (combinational).
  - rd_valid = rvalid, rd_data = rdata, rd_last = rlast, rd_owner = latched owner (combinational pass-through, zero latency).
  - An 8-bit beat counter increments on each rvalid&&rready.
  - On the rlast handshake: pulse burst_done[owner] next cycle and return to IDLE. A new arbitration may start that same IDLE cycle, giving a minimum 2-cycle gap between bursts.
- Errors (m00_axi_error is set and stays set until reset):
  - rresp != 0 on any accepted beat.
  - rlast accepted with beat counter != latched arlen.
  - Beat count reaching arlen+1 without rlast. In this case the controller keeps accepting beats until rlast.
- Requests are sampled only in IDLE. Requests deasserted before grant are dropped without a grant.
- vid_req and aud_req asserted in the same cycle: video wins. The audio request stays pending.
- Address width rules: no 4 KB-boundary splitting; requesters guarantee legal bursts.

Optional Feature:
- Macro: AUDIO_STARVE_GUARD_EN.
- Defined:
  - starve_cnt increments on each video grant made while any aud_req is high, and clears on any audio grant.
  - When starve_cnt == STARVE_LIMIT, the next arbitration selects audio (round-robin) even if vid_req is high, then starve_cnt clears.
- Undefined: strict video priority; starve_cnt logic is absent.

Test Plan:
- Video only: vid_req with addr 0x81000000, len 63; arready after 2 cycles; 64 beats with rlast on beat 64. Expect araddr=0x81000000, arlen=63, vid_gnt pulses once, 64 rd_valid beats with rd_owner=0, burst_done[0] pulses, error=0.
- Audio round-robin: aud_req=4'b1111 held after each grant is re-raised, len 7. Expect grant order ch0, ch1, ch2, ch3, ch0, with rd_owner values 1, 2, 3, 4, 1.
- Contention: vid_req and aud_req[2] rise in the same cycle. Expect the video burst first; after its burst_done, ch2 is granted (rr_ptr=3 start).
- Backpressure: rd_ready toggles every other cycle during a 16-beat burst. Expect rready to mirror rd_ready, exactly 16 beats forwarded, and no beat lost or duplicated.
- Errors: rresp=2'b10 on beat 3, then reset. Expect the error to go high and stay high, then clear on aresetn=0. Separately, rlast on beat 5 of len 7 sets the error.
- Starvation (AUDIO_STARVE_GUARD_EN, STARVE_LIMIT=8): vid_req held continuously and aud_req[1]=1. Expect 8 video grants, then aud_gnt[1], then video resumes.

Source files
------------

// File: rtl/axi_fb_audio_read_arbiter.sv
// Shares one AXI4 read master between the HDMI line fetcher (strict priority) and four round-robin audio refill requesters.
// Latency: request to arvalid 1 cycle; R beats pass through combinationally; burst_done pulses the cycle after the rlast handshake.
// Backpressure: rready mirrors sink rd_ready during DATA; AR held stable until arready. Optional starvation guard: AUDIO_STARVE_GUARD_EN.
module axi_fb_audio_read_arbiter #(
    parameter int C_M00_AXI_ADDR_WIDTH = 32,
    parameter int C_M00_AXI_DATA_WIDTH = 64,
    parameter int C_M00_AXI_ID_WIDTH   = 1,
    parameter int N_AUD                = 4,
    parameter int STARVE_LIMIT         = 8
) (
    input  logic                                  m00_axi_aclk,
    input  logic                                  m00_axi_aresetn,
    input  logic                                  vid_req,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]       vid_addr,
    input  logic [7:0]                            vid_len,
    output logic                                  vid_gnt,
    input  logic [N_AUD-1:0]                      aud_req,
    input  logic [N_AUD*C_M00_AXI_ADDR_WIDTH-1:0] aud_addr,
    input  logic [N_AUD*8-1:0]                    aud_len,
    output logic [N_AUD-1:0]                      aud_gnt,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]       m00_axi_araddr,
    output logic [7:0]                            m00_axi_arlen,
    output logic [2:0]                            m00_axi_arsize,
    output logic [1:0]                            m00_axi_arburst,
    output logic [C_M00_AXI_ID_WIDTH-1:0]         m00_axi_arid,
    output logic                                  m00_axi_arvalid,
    input  logic                                  m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]       m00_axi_rdata,
    input  logic [1:0]                            m00_axi_rresp,
    input  logic                                  m00_axi_rlast,
    input  logic                                  m00_axi_rvalid,
    output logic                                  m00_axi_rready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]       rd_data,
    output logic                                  rd_valid,
    output logic                                  rd_last,
    output logic [2:0]                            rd_owner,
    input  logic                                  rd_ready,
    output logic [N_AUD:0]                        burst_done,
    output logic                                  m00_axi_error,
    output logic                                  m00_axi_machine_busy
);

    localparam int AUD_W = $clog2(N_AUD);
    localparam int NOWN  = N_AUD + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                          state_q, state_d;
    logic [2:0]                      owner_q;      // 0 = video, 1..N_AUD = audio ch0..
    logic [C_M00_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                      len_q;
    logic [7:0]                      beat_cnt_q;
    logic [AUD_W-1:0]                rr_ptr_q;
    logic                            err_q;
    logic [NOWN-1:0]                 done_q;

    logic                            aud_found;
    logic [AUD_W-1:0]                aud_sel;
    logic [AUD_W-1:0]                rr_idx;
    logic                            force_aud;
    logic                            pick_vid;
    logic [2:0]                      sel_owner;
    logic [C_M00_AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]                      sel_len;
    logic                            ar_hs;
    logic                            r_hs;

    assign ar_hs = (state_q == ADDR) && m00_axi_arready;
    assign r_hs  = (state_q == DATA) && m00_axi_rvalid && rd_ready;

`ifdef AUDIO_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt_q;

    // Count video grants taken while audio waits; any audio grant resets the count.
    always_ff @(posedge m00_axi_aclk) begin
        if (!m00_axi_aresetn) begin
            starve_cnt_q <= '0;
        end else if (ar_hs) begin
            if (owner_q != 3'd0) begin
                starve_cnt_q <= '0;
            end else if (|aud_req && (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
        end
    end

    assign force_aud = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
`else
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
    assign force_aud = 1'b0;
`endif

    // Round-robin search starting one past the last granted audio channel.
    always_comb begin
        aud_found = 1'b0;
        aud_sel   = rr_ptr_q;
        rr_idx    = rr_ptr_q;
        for (int i = 1; i <= N_AUD; i++) begin
            rr_idx = rr_ptr_q + AUD_W'(i);
            if (!aud_found && aud_req[rr_idx]) begin
                aud_found = 1'b1;
                aud_sel   = rr_idx;
            end
        end
    end

    assign pick_vid  = vid_req && !(force_aud && aud_found);
    assign sel_owner = pick_vid ? 3'd0 : (3'(aud_sel) + 3'd1);
    assign sel_addr  = pick_vid ? vid_addr : aud_addr[aud_sel*C_M00_AXI_ADDR_WIDTH +: C_M00_AXI_ADDR_WIDTH];
    assign sel_len   = pick_vid ? vid_len  : aud_len[aud_sel*8 +: 8];

    // State register.
    always_ff @(posedge m00_axi_aclk) begin
        if (!m00_axi_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus AR/R handshake outputs.
    always_comb begin
        state_d         = state_q;
        m00_axi_arvalid = 1'b0;
        vid_gnt         = 1'b0;
        aud_gnt         = '0;
        m00_axi_rready  = 1'b0;
        rd_valid        = 1'b0;
        rd_data         = '0;
        rd_last         = 1'b0;
        rd_owner        = 3'd0;
        case (state_q)
            IDLE: begin
                if (vid_req || aud_found) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m00_axi_arvalid = 1'b1;
                if (m00_axi_arready) begin
                    state_d = DATA;
                    if (owner_q == 3'd0) begin
                        vid_gnt = 1'b1;
                    end else begin
                        aud_gnt = N_AUD'(1) << (owner_q - 3'd1);
                    end
                end
            end
            DATA: begin
                m00_axi_rready = rd_ready;
                rd_valid       = m00_axi_rvalid;
                rd_data        = m00_axi_rdata;
                rd_last        = m00_axi_rlast;
                rd_owner       = owner_q;
                if (r_hs && m00_axi_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst context latch, round-robin pointer, beat counting, error detection and done pulse.
    always_ff @(posedge m00_axi_aclk) begin
        if (!m00_axi_aresetn) begin
            owner_q    <= 3'd0;
            addr_q     <= '0;
            len_q      <= 8'd0;
            beat_cnt_q <= 8'd0;
            rr_ptr_q   <= AUD_W'(N_AUD - 1);
            err_q      <= 1'b0;
            done_q     <= '0;
        end else begin
            done_q <= '0;
            if (state_q == IDLE && state_d == ADDR) begin
                owner_q    <= sel_owner;
                addr_q     <= sel_addr;
                len_q      <= sel_len;
                beat_cnt_q <= 8'd0;
            end
            if (ar_hs && owner_q != 3'd0) begin
                rr_ptr_q <= AUD_W'(owner_q - 3'd1);
            end
            if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
                // Bad response, early rlast, or overrun past arlen all latch the sticky flag.
                if ((m00_axi_rresp != 2'b00) ||
                    (m00_axi_rlast && beat_cnt_q != len_q) ||
                    (!m00_axi_rlast && beat_cnt_q == len_q)) begin
                    err_q <= 1'b1;
                end
                if (m00_axi_rlast) begin
                    done_q <= NOWN'(1) << owner_q;
                end
            end
        end
    end

    assign m00_axi_araddr       = addr_q;
    assign m00_axi_arlen        = len_q;
    assign m00_axi_arsize       = 3'($clog2(C_M00_AXI_DATA_WIDTH / 8));
    assign m00_axi_arburst      = 2'b01;
    assign m00_axi_arid         = '0;
    assign burst_done           = done_q;
    assign m00_axi_error        = err_q;
    assign m00_axi_machine_busy = (state_q != IDLE);

endmodule

// File: tb/tb_axi_fb_audio_read_arbiter.sv
// Directed bench for axi_fb_audio_read_arbiter: table of bursts plus hand-written error/reset/starvation sequences.
// Latency: checks 1-cycle request-to-arvalid and combinational R pass-through.
// Backpressure: sink ready toggles on one burst; rready must mirror it.
module tb_axi_fb_audio_read_arbiter;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        vid_req;
    logic [31:0] vid_addr;
    logic [7:0]  vid_len;
    logic        vid_gnt;
    logic [3:0]  aud_req;
    logic [127:0] aud_addr;
    logic [31:0] aud_len;
    logic [3:0]  aud_gnt;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [0:0]  arid;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic [2:0]  rd_owner;
    logic        rd_ready;
    logic [4:0]  burst_done;
    logic        axi_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_fb_audio_read_arbiter dut (
        .m00_axi_aclk        (clk),
        .m00_axi_aresetn     (aresetn),
        .vid_req             (vid_req),
        .vid_addr            (vid_addr),
        .vid_len             (vid_len),
        .vid_gnt             (vid_gnt),
        .aud_req             (aud_req),
        .aud_addr            (aud_addr),
        .aud_len             (aud_len),
        .aud_gnt             (aud_gnt),
        .m00_axi_araddr      (araddr),
        .m00_axi_arlen       (arlen),
        .m00_axi_arsize      (arsize),
        .m00_axi_arburst     (arburst),
        .m00_axi_arid        (arid),
        .m00_axi_arvalid     (arvalid),
        .m00_axi_arready     (arready),
        .m00_axi_rdata       (rdata),
        .m00_axi_rresp       (rresp),
        .m00_axi_rlast       (rlast),
        .m00_axi_rvalid      (rvalid),
        .m00_axi_rready      (rready),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .rd_last             (rd_last),
        .rd_owner            (rd_owner),
        .rd_ready            (rd_ready),
        .burst_done          (burst_done),
        .m00_axi_error       (axi_error),
        .m00_axi_machine_busy(busy)
    );

    typedef struct {
        logic        vreq;
        logic [31:0] vaddr;
        logic [7:0]  vlen;
        logic [3:0]  areq;
        logic [7:0]  alen;
        int          ar_wait;
        int          nbeats;
        int          last_beat;
        int          err_beat;
        bit          bp;
        bit          hold;
        logic [2:0]  exp_owner;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vreq, input logic [31:0] vaddr, input logic [7:0] vlen,
                                input logic [3:0] areq, input logic [7:0] alen, input int ar_wait,
                                input int nbeats, input int last_beat, input int err_beat,
                                input bit bp, input bit hold, input logic [2:0] own,
                                input logic [31:0] ea, input logic [7:0] el, input logic ee);
        vec_t v;
        v.vreq = vreq; v.vaddr = vaddr; v.vlen = vlen; v.areq = areq; v.alen = alen;
        v.ar_wait = ar_wait; v.nbeats = nbeats; v.last_beat = last_beat; v.err_beat = err_beat;
        v.bp = bp; v.hold = hold; v.exp_owner = own; v.exp_addr = ea; v.exp_len = el; v.exp_err = ee;
        return v;
    endfunction

    // Leaves the bench at posedge+1 of the first IDLE cycle after reset release.
    task automatic do_reset();
        @(posedge clk); #1;
        aresetn = 1'b0;
        vid_req = 1'b0; aud_req = 4'b0; arready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b0; rdata = '0; rd_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arlen", arlen, 8'h0);
        chk("rst_arsize", arsize, 3'd3);
        chk("rst_arburst", arburst, 2'b01);
        chk("rst_arid", arid, 1'b0);
        chk("rst_gnts", {vid_gnt, aud_gnt}, 5'b0);
        chk("rst_rd", {rready, rd_valid, rd_last, rd_owner}, 6'b0);
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_done", burst_done, 5'b0);
        chk("rst_error", axi_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        aresetn = 1'b1;
    endtask

    // Called at posedge+1 of an IDLE cycle; runs one burst acting as slave and sink.
    task automatic run_vec(input vec_t v);
        int n;
        int b;
        int cyc;
        int fwd;
        logic [3:0]  exp_ag;
        logic [63:0] dat;
        vid_req  = v.vreq;
        vid_addr = v.vaddr;
        vid_len  = v.vlen;
        aud_req  = v.areq;
        aud_len  = {4{v.alen}};
        n = 0;
        @(negedge clk);
        while (arvalid !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("ar_latency", n, 1);
        if (arvalid !== 1'b1) return;
        chk("araddr", araddr, v.exp_addr);
        chk("arlen", arlen, v.exp_len);
        chk("arsize_burst", {arsize, arburst}, {3'd3, 2'b01});
        chk("busy_addr", busy, 1'b1);
        for (int i = 0; i < v.ar_wait; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("ar_hold_valid", arvalid, 1'b1);
            chk("ar_hold_addr", araddr, v.exp_addr);
            chk("ar_hold_nogrant", {vid_gnt, aud_gnt}, 5'b0);
        end
        @(posedge clk); #1;
        arready = 1'b1;
        @(negedge clk);
        exp_ag = (v.exp_owner == 3'd0) ? 4'b0 : (4'b1 << (v.exp_owner - 3'd1));
        chk("vid_gnt", vid_gnt, (v.exp_owner == 3'd0));
        chk("aud_gnt", aud_gnt, exp_ag);
        @(posedge clk); #1;
        arready = 1'b0;
        if (!v.hold) begin
            if (v.exp_owner == 3'd0) vid_req = 1'b0;
            else aud_req[int'(v.exp_owner) - 1] = 1'b0;
        end
        @(negedge clk);
        chk("gnt_single", {vid_gnt, aud_gnt}, 5'b0);
        chk("arvalid_clr", arvalid, 1'b0);
        b = 0; cyc = 0; fwd = 0;
        while (b < v.nbeats && cyc < 4 * v.nbeats + 8) begin
            @(posedge clk); #1;
            dat      = {32'hC0DE0000 | 32'(v.exp_owner), 32'(b)};
            rvalid   = 1'b1;
            rdata    = dat;
            rlast    = (b == v.last_beat);
            rresp    = (b == v.err_beat) ? 2'b10 : 2'b00;
            rd_ready = v.bp ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            chk("rready_mirror", rready, rd_ready);
            chk("rd_valid", rd_valid, 1'b1);
            if (rd_valid && rd_ready) fwd++;
            if (rready === 1'b1) begin
                chk("rd_data", rd_data, dat);
                chk("rd_owner", rd_owner, v.exp_owner);
                chk("rd_last", rd_last, (b == v.last_beat));
                b++;
            end
            cyc++;
        end
        chk("beats_fwd", fwd, v.nbeats);
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rd_ready = 1'b1;
        chk("burst_done", burst_done, 5'b1 << v.exp_owner);
        chk("busy_idle", busy, 1'b0);
        chk("error_flag", axi_error, v.exp_err);
    endtask

    initial begin
        vec_t sv;
        aresetn  = 1'b0;
        vid_req  = 1'b0; vid_addr = '0; vid_len = '0;
        aud_req  = '0;   aud_len = '0;
        aud_addr = {32'h90003000, 32'h90002000, 32'h90001000, 32'h90000000};
        arready  = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0; rdata = '0; rd_ready = 1'b1;

        //          vreq vaddr          vlen  areq     alen  arw nb  last err bp hold own  exp_addr      len  err
        vecs[0] = mk(1, 32'h81000000, 8'd63, 4'b0000, 8'd7,  2, 64, 63, -1, 0, 0, 3'd0, 32'h81000000, 8'd63, 0);
        vecs[1] = mk(0, 32'h0,        8'd0,  4'b1111, 8'd7,  0,  8,  7, -1, 0, 1, 3'd1, 32'h90000000, 8'd7,  0);
        vecs[2] = mk(0, 32'h0,        8'd0,  4'b1111, 8'd7,  1,  8,  7, -1, 0, 1, 3'd2, 32'h90001000, 8'd7,  0);
        vecs[3] = mk(0, 32'h0,        8'd0,  4'b1111, 8'd7,  0,  8,  7, -1, 0, 1, 3'd3, 32'h90002000, 8'd7,  0);
        vecs[4] = mk(0, 32'h0,        8'd0,  4'b1111, 8'd7,  1,  8,  7, -1, 0, 1, 3'd4, 32'h90003000, 8'd7,  0);
        vecs[5] = mk(0, 32'h0,        8'd0,  4'b1111, 8'd7,  0,  8,  7, -1, 0, 1, 3'd1, 32'h90000000, 8'd7,  0);
        vecs[6] = mk(1, 32'h82000040, 8'd3,  4'b0100, 8'd15, 1,  4,  3, -1, 0, 0, 3'd0, 32'h82000040, 8'd3,  0);
        vecs[7] = mk(0, 32'h0,        8'd0,  4'b0100, 8'd15, 0, 16, 15, -1, 1, 0, 3'd3, 32'h90002000, 8'd15, 0);

        do_reset();
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // rresp error mid-burst stays sticky until reset.
        do_reset();
        run_vec(mk(1, 32'h81000100, 8'd7, 4'b0000, 8'd7, 0, 8, 7, 3, 0, 0, 3'd0, 32'h81000100, 8'd7, 1));
        repeat (3) @(posedge clk);
        #1;
        chk("error_sticky", axi_error, 1'b1);
        do_reset();
        chk("error_cleared", axi_error, 1'b0);

        // rlast on beat 5 of an 8-beat audio burst.
        run_vec(mk(0, 32'h0, 8'd0, 4'b0001, 8'd7, 0, 5, 4, -1, 0, 0, 3'd1, 32'h90000000, 8'd7, 1));

        // Slave overruns arlen: beats keep flowing until rlast.
        do_reset();
        run_vec(mk(1, 32'h81000200, 8'd3, 4'b0000, 8'd0, 0, 6, 5, -1, 0, 0, 3'd0, 32'h81000200, 8'd3, 1));

        // Video held continuously with audio ch1 pending.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sv = mk(1, 32'h83000000, 8'd0, 4'b0010, 8'd0, 0, 1, 0, -1, 0, 1, 3'd0, 32'h83000000, 8'd0, 0);
`ifdef AUDIO_STARVE_GUARD_EN
            if (k == 8) begin
                sv.exp_owner = 3'd2;
                sv.exp_addr  = 32'h90001000;
            end
`endif
            run_vec(sv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
